// File: rtl/gate_access_arbiter.sv
// Round-robin arbiter for a shared parking barrier: grants one lane, checks
// its PIN, opens the gate until the vehicle clears, locks out after bad PINs.
module gate_access_arbiter #(
    parameter logic [7:0] PIN_ENTRADA  = 8'h08,
    parameter logic [7:0] PIN_SALIDA   = 8'h21,
    parameter int         MAX_INTENTOS = 3,
    parameter int         TIMEOUT      = 50
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Vehiculo_E,
    input  logic [7:0] Pin_E,
    input  logic       Vehiculo_S,
    input  logic [7:0] Pin_S,
    input  logic       Termino,
    output logic       Cerrado,
    output logic       Abierto,
    output logic       Alarma,
    output logic       Bloqueo,
    output logic       Turno,
    output logic       Ocupado,
    output logic       Espera,
    output logic [2:0] Intentos
);

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        ESPERA_PIN = 2'd1,
        ABIERTO    = 2'd2,
        BLOQUEO    = 2'd3
    } state_t;

    localparam logic [2:0] MAX_I   = 3'(MAX_INTENTOS);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       turno_q, turno_d;
    logic [2:0] intentos_q, intentos_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_served_q, last_served_d;
    logic       pin_prev_e_q, pin_prev_s_q;
    logic       cerrado_q, abierto_q, alarma_q, bloqueo_q, ocupado_q;

    logic       ev_e, ev_s, ev_g, pin_ok;
    logic       veh_g;

    // Rising-edge detect on "keypad non-idle", tracked on both lanes always.
    assign ev_e   = (Pin_E != 8'h00) && !pin_prev_e_q;
    assign ev_s   = (Pin_S != 8'h00) && !pin_prev_s_q;
    assign ev_g   = turno_q ? ev_s : ev_e;
    assign pin_ok = turno_q ? (Pin_S == PIN_SALIDA) : (Pin_E == PIN_ENTRADA);
    assign veh_g  = turno_q ? Vehiculo_S : Vehiculo_E;

    always_comb begin
        state_d       = state_q;
        turno_d       = turno_q;
        intentos_d    = intentos_q;
        cnt_d         = cnt_q;
        last_served_d = last_served_q;
        case (state_q)
            REPOSO: begin
                if (Vehiculo_E || Vehiculo_S) begin
                    state_d    = ESPERA_PIN;
                    intentos_d = 3'd0;
                    cnt_d      = 8'd0;
                    if (Vehiculo_E && Vehiculo_S) turno_d = ~last_served_q;
                    else                          turno_d = Vehiculo_S;
                end
            end
            ESPERA_PIN: begin
                if (ev_g && pin_ok) begin
                    state_d = ABIERTO;
                end else if (ev_g) begin
                    intentos_d = intentos_q + 3'd1;
                    if (intentos_d == MAX_I) state_d = BLOQUEO;
                    else if (cnt_q < TO_LAST) cnt_d = cnt_q + 8'd1;
                end else if (!veh_g || (cnt_q >= TO_LAST)) begin
                    state_d    = REPOSO;
                    intentos_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ABIERTO: begin
                if (Termino) begin
                    state_d       = REPOSO;
                    last_served_d = turno_q;
                    intentos_d    = 3'd0;
                end
            end
            BLOQUEO: begin
                if (ev_g && pin_ok) begin
                    state_d       = REPOSO;
                    last_served_d = turno_q;
                    intentos_d    = 3'd0;
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= REPOSO;
            turno_q       <= 1'b0;
            intentos_q    <= 3'd0;
            cnt_q         <= 8'd0;
            last_served_q <= 1'b1;
            pin_prev_e_q  <= 1'b0;
            pin_prev_s_q  <= 1'b0;
            cerrado_q     <= 1'b1;
            abierto_q     <= 1'b0;
            alarma_q      <= 1'b0;
            bloqueo_q     <= 1'b0;
            ocupado_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            turno_q       <= turno_d;
            intentos_q    <= intentos_d;
            cnt_q         <= cnt_d;
            last_served_q <= last_served_d;
            pin_prev_e_q  <= (Pin_E != 8'h00);
            pin_prev_s_q  <= (Pin_S != 8'h00);
            // Output flops decode the next state so they track state_q exactly.
            cerrado_q     <= (state_d != ABIERTO);
            abierto_q     <= (state_d == ABIERTO);
            alarma_q      <= (state_d == BLOQUEO);
            bloqueo_q     <= (state_d == BLOQUEO);
            ocupado_q     <= (state_d != REPOSO);
        end
    end

    assign Cerrado  = cerrado_q;
    assign Abierto  = abierto_q;
    assign Alarma   = alarma_q;
    assign Bloqueo  = bloqueo_q;
    assign Turno    = turno_q;
    assign Ocupado  = ocupado_q;
    assign Intentos = intentos_q;
    assign Espera   = ocupado_q && (turno_q ? Vehiculo_E : Vehiculo_S);

endmodule

// File: tb/tb_gate_access_arbiter.sv
// Directed bench for gate_access_arbiter: a vector table plus a hand-written
// timeout sequence, all expectations computed by hand.
module tb_gate_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       veh_e, veh_s, termino;
  logic [7:0] pin_e, pin_s;
  logic       cerrado, abierto, alarma, bloqueo, turno, ocupado, espera;
  logic [2:0] intentos;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_access_arbiter dut (
    .Clk(clk), .Reset(reset),
    .Vehiculo_E(veh_e), .Pin_E(pin_e),
    .Vehiculo_S(veh_s), .Pin_S(pin_s),
    .Termino(termino),
    .Cerrado(cerrado), .Abierto(abierto), .Alarma(alarma), .Bloqueo(bloqueo),
    .Turno(turno), .Ocupado(ocupado), .Espera(espera), .Intentos(intentos)
  );

  typedef struct {
    logic       r, ve;
    logic [7:0] pe;
    logic       vs;
    logic [7:0] ps;
    logic       t;
    logic       c, a, al, b, tu, o, es;
    logic [2:0] in;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic ve, input logic [7:0] pe,
                     input logic vs, input logic [7:0] ps, input logic t,
                     input logic c, input logic a, input logic al, input logic b,
                     input logic tu, input logic o, input logic es,
                     input logic [2:0] in);
    vec_t v;
    v.r = r; v.ve = ve; v.pe = pe; v.vs = vs; v.ps = ps; v.t = t;
    v.c = c; v.a = a; v.al = al; v.b = b; v.tu = tu; v.o = o; v.es = es;
    v.in = in;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d @%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ve, input logic [7:0] pe,
                       input logic vs, input logic [7:0] ps, input logic t);
    @(negedge clk);
    reset = r; veh_e = ve; pin_e = pe; veh_s = vs; pin_s = ps; termino = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".cerrado"}, cerrado, v.c);
    chk({p, ".abierto"}, abierto, v.a);
    chk({p, ".alarma"}, alarma, v.al);
    chk({p, ".bloqueo"}, bloqueo, v.b);
    chk({p, ".ocupado"}, ocupado, v.o);
    chk({p, ".espera"}, espera, v.es);
    chk({p, ".intentos"}, intentos, v.in);
    if (v.o || v.r) chk({p, ".turno"}, turno, v.tu);
    chk({p, ".excl"}, int'(cerrado && abierto), 0);
  endtask

  initial begin
    reset = 1'b1; veh_e = 0; veh_s = 0; pin_e = 0; pin_s = 0; termino = 0;

    //   r ve pe     vs ps     t   C A Al B Tu O Es In
    // Entry lane, correct PIN, then vehicle clears
    add(1, 0, 8'h00, 0, 8'h00, 0,  1,0,0,0, 0,0,0, 0);
    add(0, 1, 8'h00, 0, 8'h00, 0,  1,0,0,0, 0,1,0, 0);
    add(0, 1, 8'h08, 0, 8'h00, 0,  0,1,0,0, 0,1,0, 0);
    add(0, 1, 8'h00, 0, 8'h00, 0,  0,1,0,0, 0,1,0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,  1,0,0,0, 0,0,0, 0);
    // Simultaneous arrival: entry first, then round-robin to exit
    add(1, 0, 8'h00, 0, 8'h00, 0,  1,0,0,0, 0,0,0, 0);
    add(0, 1, 8'h00, 1, 8'h00, 0,  1,0,0,0, 0,1,1, 0);
    add(0, 1, 8'h08, 1, 8'h00, 0,  0,1,0,0, 0,1,1, 0);
    add(0, 1, 8'h00, 1, 8'h00, 1,  1,0,0,0, 0,0,0, 0);
    add(0, 1, 8'h00, 1, 8'h00, 0,  1,0,0,0, 1,1,1, 0);
    // Exit lane: three wrong PINs -> lockout, then correct PIN releases
    add(0, 0, 8'h00, 1, 8'hFF, 0,  1,0,0,0, 1,1,0, 1);
    add(0, 0, 8'h00, 1, 8'h00, 0,  1,0,0,0, 1,1,0, 1);
    add(0, 0, 8'h00, 1, 8'hFF, 0,  1,0,0,0, 1,1,0, 2);
    add(0, 0, 8'h00, 1, 8'h00, 0,  1,0,0,0, 1,1,0, 2);
    add(0, 0, 8'h00, 1, 8'hFF, 0,  1,0,1,1, 1,1,0, 3);
    add(0, 1, 8'h00, 1, 8'h00, 0,  1,0,1,1, 1,1,1, 3);
    add(0, 1, 8'h00, 1, 8'hFF, 0,  1,0,1,1, 1,1,1, 3);
    add(0, 1, 8'h00, 1, 8'h00, 0,  1,0,1,1, 1,1,1, 3);
    add(0, 1, 8'h00, 1, 8'h21, 0,  1,0,0,0, 1,0,0, 0);
    // PIN held across the grant gives no event; re-press opens
    add(1, 0, 8'h00, 0, 8'h00, 0,  1,0,0,0, 0,0,0, 0);
    add(0, 0, 8'h08, 0, 8'h00, 0,  1,0,0,0, 0,0,0, 0);
    add(0, 1, 8'h08, 0, 8'h00, 0,  1,0,0,0, 0,1,0, 0);
    add(0, 1, 8'h08, 0, 8'h00, 0,  1,0,0,0, 0,1,0, 0);
    add(0, 1, 8'h00, 0, 8'h00, 0,  1,0,0,0, 0,1,0, 0);
    add(0, 1, 8'h08, 0, 8'h00, 0,  0,1,0,0, 0,1,0, 0);
    // Reset during ABIERTO; other-lane PIN ignored; reset during BLOQUEO
    add(1, 1, 8'h08, 0, 8'h00, 0,  1,0,0,0, 0,0,0, 0);
    add(0, 1, 8'h08, 0, 8'h00, 0,  1,0,0,0, 0,1,0, 0);
    add(0, 1, 8'h08, 1, 8'h21, 0,  1,0,0,0, 0,1,1, 0);
    add(0, 1, 8'h00, 1, 8'h00, 0,  1,0,0,0, 0,1,1, 0);
    add(0, 1, 8'h55, 1, 8'h00, 0,  1,0,0,0, 0,1,1, 1);
    add(0, 1, 8'h00, 1, 8'h00, 0,  1,0,0,0, 0,1,1, 1);
    add(0, 1, 8'h55, 1, 8'h00, 0,  1,0,0,0, 0,1,1, 2);
    add(0, 1, 8'h00, 1, 8'h00, 0,  1,0,0,0, 0,1,1, 2);
    add(0, 1, 8'h55, 1, 8'h00, 0,  1,0,1,1, 0,1,1, 3);
    add(1, 1, 8'h00, 1, 8'h00, 0,  1,0,0,0, 0,0,0, 0);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].ve, vq[i].pe, vq[i].vs, vq[i].ps, vq[i].t);
      check_vec(i, vq[i]);
    end

    // Timeout: entry granted, exit waiting, no PIN for TIMEOUT cycles
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    drive(0, 1, 8'h00, 0, 8'h00, 0);
    chk("to.grant_ocupado", ocupado, 1);
    chk("to.grant_turno", turno, 0);
    for (int i = 1; i < 50; i++) begin
      drive(0, 1, 8'h00, 1, 8'h00, 0);
      chk($sformatf("to.wait%0d_ocupado", i), ocupado, 1);
      chk($sformatf("to.wait%0d_espera", i), espera, 1);
    end
    drive(0, 1, 8'h00, 1, 8'h00, 0);
    chk("to.expire_ocupado", ocupado, 0);
    chk("to.expire_cerrado", cerrado, 1);
    chk("to.expire_intentos", intentos, 0);
    drive(0, 0, 8'h00, 1, 8'h00, 0);
    chk("to.next_ocupado", ocupado, 1);
    chk("to.next_turno", turno, 1);
    chk("to.next_cerrado", cerrado, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
